key_step_ctrl: RTL and testbench

KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

---
 rtl/key_step_ctrl.sv | 171 +++++++++++++++++
 tb/tb_key_step_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_step_ctrl.sv
// key_step_ctrl
// Turns four debounced, active-low step keys into single-cycle step pulses
// with typematic auto-repeat: one pulse on press, a long hold delay, a
// number of slow repeats, then fast repeats until the key is released.
// Pressing more than one key at once locks the controller out until every
// key has been released.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key_n[3:0] debounced keys, active-low
//              bit0 fine-up, bit1 fine-down, bit2 coarse-up, bit3 coarse-down
//   step_up    one-cycle pulse, increment units digit
//   step_dn    one-cycle pulse, decrement units digit
//   step_lup   one-cycle pulse, increment 10^4 digit
//   step_ldn   one-cycle pulse, decrement 10^4 digit
//   repeating  high while auto-repeat (slow or fast) is active
module key_step_ctrl #(
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned RPT_CYC  = 5_000_000,
  parameter int unsigned FAST_CYC = 1_000_000,
  parameter int unsigned FAST_CNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic       step_up,
  output logic       step_dn,
  output logic       step_lup,
  output logic       step_ldn,
  output logic       repeating
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    SLOW,
    FAST,
    LOCK
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rpt_q, rpt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  step_q, step_d;
  logic        pulse_d;

  logic [3:0]  pressed;
  logic        single;
  logic [1:0]  pressIdx;

  assign pressed = ~key_n;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign single  = (pressed != 4'd0) && ((pressed & (pressed - 4'd1)) == 4'd0);

  // Index of the pressed key; only consulted when a single key is down.
  always_comb begin
    pressIdx = 2'd0;
    case (pressed)
      4'b0010: pressIdx = 2'd1;
      4'b0100: pressIdx = 2'd2;
      4'b1000: pressIdx = 2'd3;
      default: pressIdx = 2'd0;
    endcase
  end

  // State register plus counters, captured key and the registered step pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      rpt_q   <= 32'd0;
      idx_q   <= 2'd0;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic. Release and key-change checks take priority over the
  // timers, so no pulse is ever emitted in the cycle a key set changes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    rpt_d   = rpt_q;
    idx_d   = idx_q;
    pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        rpt_d = 32'd0;
        if (single) begin
          state_d = HOLD;
          idx_d   = pressIdx;
          pulse_d = 1'b1;
        end else if (pressed != 4'd0) begin
          state_d = LOCK;
        end
      end

      HOLD, SLOW, FAST: begin
        if (pressed == 4'd0) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else if (pressed != (4'b0001 << idx_q)) begin
          state_d = LOCK;
          cnt_d   = 32'd0;
        end else begin
          case (state_q)
            HOLD: begin
              if (cnt_q == HOLD_CYC - 32'd1) begin
                state_d = SLOW;
                pulse_d = 1'b1;
                cnt_d   = 32'd0;
                rpt_d   = 32'd0;
              end
            end
            SLOW: begin
              if (cnt_q == RPT_CYC - 32'd1) begin
                pulse_d = 1'b1;
                cnt_d   = 32'd0;
                // The entry pulse into SLOW is not a repeat; switch to the
                // fast period once FAST_CNT timed repeats have been emitted.
                if (rpt_q + 32'd1 >= FAST_CNT) begin
                  state_d = FAST;
                  rpt_d   = FAST_CNT;
                end else begin
                  rpt_d   = rpt_q + 32'd1;
                end
              end
            end
            default: begin
              if (cnt_q == FAST_CYC - 32'd1) begin
                pulse_d = 1'b1;
                cnt_d   = 32'd0;
              end
            end
          endcase
        end
      end

      default: begin
        cnt_d = 32'd0;
        if (pressed == 4'd0) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Route the pulse to the output of the captured key.
  always_comb begin
    step_d = 4'd0;
    if (pulse_d) begin
      step_d = 4'b0001 << idx_d;
    end
  end

  assign step_up   = step_q[0];
  assign step_dn   = step_q[1];
  assign step_lup  = step_q[2];
  assign step_ldn  = step_q[3];
  assign repeating = (state_q == SLOW) || (state_q == FAST);

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb_key_step_ctrl
// Drives directed key scenarios and randomized key sequences into
// key_step_ctrl and compares every cycle against a timeline model: pulse
// instants are computed from the time elapsed since the key went down.
module tb_key_step_ctrl;

  localparam int H  = 20;
  localparam int R  = 8;
  localparam int FC = 4;
  localparam int FN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keyN;
  logic       stepUp, stepDn, stepLup, stepLdn, repeating;

  always #5 clk = ~clk;

  key_step_ctrl #(
    .HOLD_CYC (H),
    .RPT_CYC  (R),
    .FAST_CYC (FC),
    .FAST_CNT (FN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (keyN),
    .step_up   (stepUp),
    .step_dn   (stepDn),
    .step_lup  (stepLup),
    .step_ldn  (stepLdn),
    .repeating (repeating)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef enum {M_IDLE, M_ACT, M_LOCK} mode_t;
  mode_t      mode = M_IDLE;
  int         keyIdx = 0;
  int         elapsed = 0;
  logic [3:0] expStep = 4'd0;
  logic       expRep = 1'b0;
  logic [3:0] prevStep = 4'd0;
  int         stepCount [4];

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pulse instants as edges elapsed since the press edge.
  function automatic bit isPulse(input int k);
    if (k == 0 || k == H) return 1'b1;
    if (k > H && k <= H + R * FN) return ((k - H) % R) == 0;
    if (k > H + R * FN) return ((k - H - R * FN) % FC) == 0;
    return 1'b0;
  endfunction

  // Advance the model by one rising edge with the pressed set p.
  task automatic modelStep(input logic [3:0] p);
    expStep = 4'd0;
    if (rst) begin
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE: begin
          if ($countones(p) == 1) begin
            mode    = M_ACT;
            elapsed = 0;
            for (int b = 0; b < 4; b++) if (p[b]) keyIdx = b;
            expStep[keyIdx] = 1'b1;
          end else if (p != 4'd0) begin
            mode = M_LOCK;
          end
        end
        M_ACT: begin
          if (p == 4'd0) mode = M_IDLE;
          else if ($countones(p) != 1 || !p[keyIdx]) mode = M_LOCK;
          else begin
            elapsed++;
            if (isPulse(elapsed)) expStep[keyIdx] = 1'b1;
          end
        end
        default: if (p == 4'd0) mode = M_IDLE;
      endcase
    end
    expRep = (mode == M_ACT) && (elapsed >= H);
  endtask

  // Hold key value k (and reset level r) for the given number of cycles,
  // checking outputs 1 time unit after every rising edge.
  task automatic applyStimulus(input logic [3:0] k, input int cycles, input bit r = 1'b0);
    logic [3:0] obs;
    for (int i = 0; i < cycles; i++) begin
      keyN = k;
      rst  = r;
      @(posedge clk);
      modelStep(~k);
      #1;
      obs = {stepLdn, stepLup, stepDn, stepUp};
      checkOutput("step", {28'd0, obs}, {28'd0, expStep});
      checkOutput("repeating", {31'd0, repeating}, {31'd0, expRep});
      checkOutput("oneHot", {31'd0, ($countones(obs) <= 1)}, 32'd1);
      checkOutput("noDouble", {28'd0, obs & prevStep}, 32'd0);
      for (int b = 0; b < 4; b++) if (obs[b]) stepCount[b]++;
      prevStep = obs;
    end
  endtask

  task automatic clearCounts();
    for (int b = 0; b < 4; b++) stepCount[b] = 0;
  endtask

  initial begin
    logic [3:0] k;
    int sel;
    int dur;

    clearCounts();
    rst  = 1'b1;
    keyN = 4'hF;
    #1;
    checkOutput("resetStep", {28'd0, stepLdn, stepLup, stepDn, stepUp}, 32'd0);
    checkOutput("resetRep", {31'd0, repeating}, 32'd0);
    applyStimulus(4'hF, 3, 1'b1);
    applyStimulus(4'hF, 2);

    // Short tap: exactly one step_up.
    clearCounts();
    applyStimulus(4'b1110, 5);
    applyStimulus(4'b1111, 4);
    checkOutput("tapUpCount", stepCount[0], 32'd1);

    // Long hold on fine-down: 1 + 1 + 3 slow + 8 fast pulses in 80 cycles.
    clearCounts();
    applyStimulus(4'b1101, 80);
    applyStimulus(4'b1111, 10);
    checkOutput("holdDnCount", stepCount[1], 32'd13);

    // Two keys lock out; partial release stays locked.
    clearCounts();
    applyStimulus(4'b1001, 4);
    applyStimulus(4'b1011, 4);
    checkOutput("lockNoPulse", stepCount[2] + stepCount[1] + stepCount[0] + stepCount[3], 32'd0);
    applyStimulus(4'b1111, 2);
    applyStimulus(4'b1011, 3);
    applyStimulus(4'b1111, 2);
    checkOutput("lockThenLup", stepCount[2], 32'd1);

    // Adding a key during SLOW stops pulses at once.
    clearCounts();
    applyStimulus(4'b0111, 35);
    applyStimulus(4'b0110, 20);
    applyStimulus(4'b1111, 2);
    checkOutput("slowAddKey", stepCount[3], 32'd3);

    // Reset during FAST with the key still held, then a fresh press.
    clearCounts();
    applyStimulus(4'b1110, 55);
    applyStimulus(4'b1110, 2, 1'b1);
    applyStimulus(4'b1110, 22);
    applyStimulus(4'b1111, 2);

    // Release and re-press in consecutive cycles.
    applyStimulus(4'b1101, 25);
    applyStimulus(4'b1111, 1);
    applyStimulus(4'b1101, 22);
    applyStimulus(4'b1111, 2);

    // Randomized key sequences, biased towards long single-key holds.
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 14);
      if (sel < 7) k = ~(4'b0001 << $urandom_range(0, 3));
      else if (sel < 10) k = 4'hF;
      else k = 4'($urandom);
      dur = $urandom_range(1, 70);
      if (sel == 14) applyStimulus(k, 2, 1'b1);
      else applyStimulus(k, dur);
    end
    applyStimulus(4'hF, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
